// File: rtl/mest_pro_v2.sv
// Small sequencer that fetches instructions (op,K,A,B), runs a 5-op ALU,
// jumps, calls and returns through a return-address stack, and halts.
// Each instruction takes FETCH+DECODE+EXECUTE (3 cycles min) plus fetch waits.
module mest_pro_v2 #(
  parameter int OP_CODE_SIZE     = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ROM_DEPTH        = 256,
  parameter int STACK_DEPTH      = 4,
  localparam int PC_W            = $clog2(ROM_DEPTH),
  localparam int INSTRUCTION_SIZE = OP_CODE_SIZE + 3 * DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic                        o_req,
  output logic [PC_W-1:0]             o_prog_counter,
  input  logic                        i_instr_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_instruction,
  output logic [DATA_WIDTH-1:0]       o_result,
  output logic                        o_valid_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_all_done,
  output logic                        o_stack_err
);

  // Stack pointer counts entries (0..STACK_DEPTH); the index width addresses
  // the entries themselves.
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [OP_CODE_SIZE-1:0] OP_NOP  = OP_CODE_SIZE'(0);
  localparam logic [OP_CODE_SIZE-1:0] OP_ADD  = OP_CODE_SIZE'(1);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB  = OP_CODE_SIZE'(2);
  localparam logic [OP_CODE_SIZE-1:0] OP_AND  = OP_CODE_SIZE'(3);
  localparam logic [OP_CODE_SIZE-1:0] OP_OR   = OP_CODE_SIZE'(4);
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR  = OP_CODE_SIZE'(5);
  localparam logic [OP_CODE_SIZE-1:0] OP_JMP  = OP_CODE_SIZE'(6);
  localparam logic [OP_CODE_SIZE-1:0] OP_JZ   = OP_CODE_SIZE'(7);
  localparam logic [OP_CODE_SIZE-1:0] OP_CALL = OP_CODE_SIZE'(8);
  localparam logic [OP_CODE_SIZE-1:0] OP_RET  = OP_CODE_SIZE'(9);
  localparam logic [OP_CODE_SIZE-1:0] OP_HALT = OP_CODE_SIZE'(15);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                      state_q;
  logic [PC_W-1:0]             pc_q;
  logic [SP_W-1:0]             sp_q;
  logic [PC_W-1:0]             stack_q [STACK_DEPTH];
  logic [INSTRUCTION_SIZE-1:0] instr_q;

  // Decoded fields, split out of instr_q during DECODE.
  logic [OP_CODE_SIZE-1:0]     op_q;
  logic [DATA_WIDTH-1:0]       k_q;
  logic [DATA_WIDTH-1:0]       a_q;
  logic [DATA_WIDTH-1:0]       b_q;

  // Registered outputs.
  logic                        req_q;
  logic [DATA_WIDTH-1:0]       result_q;
  logic                        valid_q;
  logic                        carry_q;
  logic                        zero_q;
  logic                        done_q;
  logic                        err_q;

  // Combinational next-value helpers used by EXECUTE.
  logic [PC_W-1:0]             pc_inc_d;
  logic [PC_W-1:0]             k_pc_d;
  logic [DATA_WIDTH:0]         sum_ext_d;
  logic [DATA_WIDTH:0]         diff_ext_d;
  logic [DATA_WIDTH-1:0]       alu_res_d;
  logic                        alu_carry_d;
  logic                        is_alu_d;
  logic                        stack_full_d;
  logic                        stack_empty_d;
  logic [SI_W-1:0]             push_idx_d;
  logic [SI_W-1:0]             top_idx_d;

  // ALU result/carry, sequential and target PC, and stack occupancy tests.
  always_comb begin
    pc_inc_d      = (pc_q == PC_W'(ROM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
    k_pc_d        = PC_W'(k_q);
    sum_ext_d     = {1'b0, a_q} + {1'b0, b_q};
    diff_ext_d    = {1'b0, a_q} - {1'b0, b_q};
    alu_res_d     = '0;
    alu_carry_d   = 1'b0;
    is_alu_d      = 1'b1;
    stack_full_d  = (sp_q == SP_W'(STACK_DEPTH));
    stack_empty_d = (sp_q == '0);
    push_idx_d    = SI_W'(sp_q);
    top_idx_d     = SI_W'(sp_q - SP_W'(1));
    case (op_q)
      OP_ADD: begin
        alu_res_d   = sum_ext_d[DATA_WIDTH-1:0];
        alu_carry_d = sum_ext_d[DATA_WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_res_d   = diff_ext_d[DATA_WIDTH-1:0];
        alu_carry_d = diff_ext_d[DATA_WIDTH];
      end
      OP_AND:  alu_res_d = a_q & b_q;
      OP_OR:   alu_res_d = a_q | b_q;
      OP_XOR:  alu_res_d = a_q ^ b_q;
      default: is_alu_d  = 1'b0;
    endcase
  end

  // Main sequencer: state, PC, stack and all registered outputs.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      instr_q  <= '0;
      op_q     <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      req_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // The result strobe is a single-cycle pulse unless EXECUTE re-arms it.
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Flags and result survive a restart from IDLE.
          if (i_start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sp_q    <= '0;
            req_q   <= 1'b1;
          end
        end

        S_FETCH: begin
          // Request and address stay put until the memory acknowledges.
          if (i_instr_valid) begin
            instr_q <= i_instruction;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          op_q    <= instr_q[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
          k_q     <= instr_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
          a_q     <= instr_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
          b_q     <= instr_q[DATA_WIDTH-1:0];
          state_q <= S_EXECUTE;
        end

        S_EXECUTE: begin
          // Default: fall through to the next sequential instruction.
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          pc_q    <= pc_inc_d;
          if (is_alu_d) begin
            result_q <= alu_res_d;
            carry_q  <= alu_carry_d;
            zero_q   <= (alu_res_d == '0);
            valid_q  <= 1'b1;
          end
          case (op_q)
            OP_JMP: pc_q <= k_pc_d;
            OP_JZ: begin
              if (zero_q) pc_q <= k_pc_d;
            end
            OP_CALL: begin
              if (stack_full_d) begin
                state_q <= S_ERROR;
                req_q   <= 1'b0;
                err_q   <= 1'b1;
                pc_q    <= pc_q;
              end else begin
                stack_q[push_idx_d] <= pc_inc_d;
                sp_q                <= sp_q + SP_W'(1);
                pc_q                <= k_pc_d;
              end
            end
            OP_RET: begin
              if (stack_empty_d) begin
                state_q <= S_ERROR;
                req_q   <= 1'b0;
                err_q   <= 1'b1;
                pc_q    <= pc_q;
              end else begin
                pc_q <= stack_q[top_idx_d];
                sp_q <= sp_q - SP_W'(1);
              end
            end
            OP_HALT: begin
              state_q <= S_DONE;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              pc_q    <= pc_q;
            end
            default: ;
          endcase
        end

        S_DONE, S_ERROR: begin
          // Terminal states hold their status level until a new run starts.
          if (i_start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            sp_q    <= '0;
            req_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req          = req_q;
  assign o_prog_counter = pc_q;
  assign o_result       = result_q;
  assign o_valid_result = valid_q;
  assign o_carry        = carry_q;
  assign o_zero_flag    = zero_q;
  assign o_all_done     = done_q;
  assign o_stack_err    = err_q;

endmodule

// File: tb/tb_mest_pro_v2.sv
// Bench for mest_pro_v2: directed programs plus random programs, all checked
// against an instruction-level interpreter of the program ROM.
module tb_mest_pro_v2;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic        o_req;
  logic [7:0]  o_prog_counter;
  logic        i_instr_valid;
  logic [27:0] i_instruction;
  logic [7:0]  o_result;
  logic        o_valid_result;
  logic        o_carry;
  logic        o_zero_flag;
  logic        o_all_done;
  logic        o_stack_err;

  always #5 clk = ~clk;

  mest_pro_v2 dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .o_req          (o_req),
    .o_prog_counter (o_prog_counter),
    .i_instr_valid  (i_instr_valid),
    .i_instruction  (i_instruction),
    .o_result       (o_result),
    .o_valid_result (o_valid_result),
    .o_carry        (o_carry),
    .o_zero_flag    (o_zero_flag),
    .o_all_done     (o_all_done),
    .o_stack_err    (o_stack_err)
  );

  int errors = 0;
  int checks = 0;

  logic [27:0] rom [256];

  // Memory responder / monitor state.
  int  wait_fixed = 0;
  bit  rand_wait  = 1'b0;
  bit  noise      = 1'b0;
  bit  in_fetch   = 1'b0;
  int  wcnt       = 0;
  int  wait_n     = 0;
  logic [7:0] fpc = 8'h00;
  int  stab_bad   = 0;
  int  pulses     = 0;
  int  vrun       = 0;
  int  vrun_max   = 0;
  int  cyc        = 0;
  int  trace[$];
  int  ftime[$];

  // Reference model state (flags persist between runs like the DUT's).
  logic [7:0] m_res   = 8'h00;
  bit         m_carry = 1'b0;
  bit         m_zero  = 1'b0;
  int         m_pulses;
  bit         m_done;
  bit         m_err;
  int         m_trace[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] mk(input int op, input int k, input int a, input int b);
    return {op[3:0], k[7:0], a[7:0], b[7:0]};
  endfunction

  function automatic int tr_at(input int i);
    if (i < trace.size()) return trace[i];
    return -1;
  endfunction

  function automatic int spacing01();
    if (ftime.size() < 2) return -1;
    return ftime[1] - ftime[0];
  endfunction

  task automatic rom_fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = mk(15, 0, 0, 0);
  endtask

  // Interpret the ROM for at most max_n instructions.
  task automatic model_run(input int max_n);
    int pc;
    int nxt;
    int stk[$];
    int steps;
    int op, k, a, b, full;
    logic [27:0] w;
    pc = 0;
    steps = 0;
    m_trace.delete();
    m_pulses = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    while (steps < max_n && !m_done && !m_err) begin
      m_trace.push_back(pc);
      w = rom[pc];
      op = int'(w[27:24]); k = int'(w[23:16]); a = int'(w[15:8]); b = int'(w[7:0]);
      steps++;
      nxt = (pc + 1) % 256;
      if (op >= 1 && op <= 5) begin
        case (op)
          1: begin full = a + b; m_res = 8'(full); m_carry = (full > 255); end
          2: begin m_res = 8'(a - b); m_carry = (a < b); end
          3: begin m_res = 8'(a & b); m_carry = 1'b0; end
          4: begin m_res = 8'(a | b); m_carry = 1'b0; end
          default: begin m_res = 8'(a ^ b); m_carry = 1'b0; end
        endcase
        m_zero = (m_res == 8'h00);
        m_pulses++;
      end else if (op == 6) begin
        nxt = k;
      end else if (op == 7) begin
        if (m_zero) nxt = k;
      end else if (op == 8) begin
        if (stk.size() == 4) m_err = 1'b1;
        else begin stk.push_back(nxt); nxt = k; end
      end else if (op == 9) begin
        if (stk.size() == 0) m_err = 1'b1;
        else nxt = stk.pop_back();
      end else if (op == 15) begin
        m_done = 1'b1;
      end
      if (!m_done && !m_err) pc = nxt;
    end
    if (!m_done && !m_err) m_trace.push_back(pc);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    m_res = 8'h00; m_carry = 1'b0; m_zero = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int max_n, input int waitf, input bit rw, input bit nz);
    bit timed_out;
    trace.delete(); ftime.delete();
    pulses = 0; vrun = 0; vrun_max = 0; stab_bad = 0;
    wait_fixed = waitf; rand_wait = rw; noise = nz;
    model_run(max_n);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (o_all_done || o_stack_err || trace.size() > max_n) begin
        timed_out = 1'b0;
        break;
      end
    end
    noise = 1'b0;
    chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  task automatic check_model(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < m_trace.size(); i++) if (tr_at(i) != m_trace[i]) mism++;
    chk({tag, "_result"}, 32'(o_result), 32'(m_res));
    chk({tag, "_carry"}, 32'(o_carry), 32'(m_carry));
    chk({tag, "_zero"}, 32'(o_zero_flag), 32'(m_zero));
    chk({tag, "_pulses"}, 32'(pulses), 32'(m_pulses));
    chk({tag, "_done"}, 32'(o_all_done), 32'(m_done));
    chk({tag, "_err"}, 32'(o_stack_err), 32'(m_err));
    chk({tag, "_tracelen"}, 32'(trace.size()), 32'(m_trace.size()));
    chk({tag, "_tracemism"}, 32'(mism), 32'd0);
    chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
    chk({tag, "_pulsewide"}, 32'(vrun_max > 1), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder and output monitor, active on the falling edge.
  initial begin
    i_instr_valid = 1'b0;
    i_instruction = '0;
    forever begin
      @(negedge clk);
      if (o_valid_result) begin
        pulses++; vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else vrun = 0;
      if (o_req) begin
        if (!in_fetch) begin
          in_fetch = 1'b1;
          wcnt = 0;
          wait_n = rand_wait ? int'($urandom_range(0, 3)) : wait_fixed;
          fpc = o_prog_counter;
          trace.push_back(int'(o_prog_counter));
          ftime.push_back(cyc);
        end else if (o_prog_counter !== fpc) stab_bad++;
        if (wcnt >= wait_n) begin
          i_instr_valid = 1'b1;
          i_instruction = rom[o_prog_counter];
        end else begin
          i_instr_valid = 1'b0;
          i_instruction = noise ? 28'($urandom) : 28'h0;
          wcnt++;
        end
      end else begin
        in_fetch = 1'b0;
        if (noise) begin
          i_instr_valid = 1'($urandom_range(0, 1));
          i_instruction = 28'($urandom);
        end else i_instr_valid = 1'b0;
      end
    end
  end

  initial begin
    i_reset_n = 1'b0;
    i_start = 1'b0;
    rom_fill_halt();
    repeat (2) @(negedge clk); #1;
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_pc", 32'(o_prog_counter), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_valid", 32'(o_valid_result), 32'd0);
    chk("rst_carry", 32'(o_carry), 32'd0);
    chk("rst_zero", 32'(o_zero_flag), 32'd0);
    chk("rst_done", 32'(o_all_done), 32'd0);
    chk("rst_err", 32'(o_stack_err), 32'd0);
    @(negedge clk); i_reset_n = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("idle_req", 32'(o_req), 32'd0);

    // ADD 0xF0+0x20 then HALT, zero-wait memory.
    rom_fill_halt();
    rom[0] = mk(1, 0, 'hF0, 'h20);
    run_prog("add", 50, 0, 1'b0, 1'b0);
    chk("add_res", 32'(o_result), 32'h10);
    chk("add_cy", 32'(o_carry), 32'd1);
    chk("add_z", 32'(o_zero_flag), 32'd0);
    chk("add_pulse", 32'(pulses), 32'd1);
    chk("add_done", 32'(o_all_done), 32'd1);
    chk("add_spacing", 32'(spacing01()), 32'd3);
    check_model("add");

    // SUB equal operands then JZ to 0x10 holding HALT.
    do_reset();
    rom_fill_halt();
    rom[0] = mk(2, 0, 5, 5);
    rom[1] = mk(7, 'h10, 0, 0);
    run_prog("jz", 50, 0, 1'b0, 1'b0);
    chk("jz_z", 32'(o_zero_flag), 32'd1);
    chk("jz_cy", 32'(o_carry), 32'd0);
    chk("jz_target", 32'(tr_at(2)), 32'h10);
    chk("jz_done", 32'(o_all_done), 32'd1);
    check_model("jz");

    // Same program with four wait cycles on every fetch.
    do_reset();
    run_prog("jzw", 50, 4, 1'b0, 1'b0);
    chk("jzw_z", 32'(o_zero_flag), 32'd1);
    chk("jzw_cy", 32'(o_carry), 32'd0);
    chk("jzw_target", 32'(tr_at(2)), 32'h10);
    chk("jzw_stable", 32'(stab_bad), 32'd0);
    chk("jzw_spacing", 32'(spacing01()), 32'd7);
    check_model("jzw");

    // Reset asserted in the middle of a fetch wait.
    do_reset();
    rom_fill_halt();
    rom[0] = mk(1, 0, 'hF0, 'h20);
    run_prog("pre", 50, 4, 1'b0, 1'b0);
    chk("pre_res", 32'(o_result), 32'h10);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    #1;
    chk("mid_req", 32'(o_req), 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(o_req), 32'd0);
    chk("arst_res", 32'(o_result), 32'd0);
    chk("arst_cy", 32'(o_carry), 32'd0);
    chk("arst_pc", 32'(o_prog_counter), 32'd0);
    chk("arst_done", 32'(o_all_done), 32'd0);
    @(negedge clk); i_reset_n = 1'b1;
    m_res = 8'h00; m_carry = 1'b0; m_zero = 1'b0;
    repeat (4) @(negedge clk); #1;
    chk("arst_idle_req", 32'(o_req), 32'd0);

    // Five nested CALLs overflow a four-entry stack.
    do_reset();
    rom_fill_halt();
    rom[0]    = mk(8, 'h10, 0, 0);
    rom['h10] = mk(8, 'h20, 0, 0);
    rom['h20] = mk(8, 'h30, 0, 0);
    rom['h30] = mk(8, 'h40, 0, 0);
    rom['h40] = mk(8, 'h50, 0, 0);
    run_prog("ovf", 50, 0, 1'b0, 1'b0);
    chk("ovf_err", 32'(o_stack_err), 32'd1);
    chk("ovf_done", 32'(o_all_done), 32'd0);
    check_model("ovf");
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    #1;
    chk("ovf_restart_err", 32'(o_stack_err), 32'd0);
    chk("ovf_restart_pc", 32'(o_prog_counter), 32'd0);
    chk("ovf_restart_req", 32'(o_req), 32'd1);

    // RET at PC 0 with an empty stack.
    do_reset();
    rom_fill_halt();
    rom[0] = mk(9, 0, 0, 0);
    run_prog("unf", 50, 0, 1'b0, 1'b0);
    chk("unf_err", 32'(o_stack_err), 32'd1);
    chk("unf_pc", 32'(o_prog_counter), 32'd0);
    check_model("unf");

    // JMP to the last address, NOP there wraps to 0.
    do_reset();
    rom_fill_halt();
    rom[0]    = mk(6, 'hFF, 0, 0);
    rom['hFF] = mk(0, 0, 0, 0);
    run_prog("wrap", 2, 0, 1'b0, 1'b0);
    chk("wrap_ff", 32'(tr_at(1)), 32'hFF);
    chk("wrap_00", 32'(tr_at(2)), 32'h00);
    check_model("wrap");

    // CALL from the last address returns to 0.
    do_reset();
    rom_fill_halt();
    rom[0]    = mk(6, 'hFF, 0, 0);
    rom['hFF] = mk(8, 'h20, 0, 0);
    rom['h20] = mk(9, 0, 0, 0);
    run_prog("cwrap", 3, 0, 1'b0, 1'b0);
    chk("cwrap_ret", 32'(tr_at(3)), 32'h00);
    check_model("cwrap");

    // Random programs, random fetch latency, junk on the bus outside FETCH.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        int op, k, a, b;
        op = int'($urandom_range(0, 15));
        k  = int'($urandom_range(0, 255));
        a  = int'($urandom_range(0, 255));
        b  = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 255));
        rom[i] = mk(op, k, a, b);
      end
      run_prog("rnd", 40, 0, 1'b1, 1'b1);
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
